mux_rr_n: RTL and testbench
===========================

Name: mux_rr_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake. It is the sequential successor to the single-bit 2:1 gate-level mux.
- Selection is made by an internal arbiter rather than an external select. The mode is round-robin or fixed-priority.
- Used in the CPU datapath wherever multiple producers share one consumer, e.g. writeback sources or memory request ports.
- One output register stage: 1-cycle latency, full throughput.

Parameters:
- WIDTH, 64, data width per channel in bits (>=1).
- N, 4, number of input channels (>=2; need not be a power of 2).
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- SELW, $clog2(N), width of the select/pointer fields (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has data.
- in_ready  output  N  channel i's data is accepted this cycle.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a valid beat.
- out_ready  input  1  consumer accepts the current beat.

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
- in_ready is all 0 while rst_n is low (combinational gate).
- Reset mid-transfer discards any held beat. There is no output for one cycle after rst_n rises.
- Output register is "free" when out_valid==0 or out_ready==1 (pipelined accept).
- Grant is combinational from in_valid and ptr:
  - RR_MODE=1: first i with in_valid[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N).
  - RR_MODE=0: lowest i with in_valid[i]=1; ptr is unused and held at 0.
- in_ready[g]=1 only for the granted g, and only when the register is free. All other in_ready bits are 0. At most one in_ready bit is high in any cycle.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. At the next edge: out_data<=in_data[g], out_sel<=g, out_valid<=1, and (RR_MODE=1) ptr<=(g+1) mod N.
- Wrap-around: g=N-1 sets ptr to 0. This holds for non-power-of-2 N; ptr never takes a value >=N.
- Register free but no in_valid: out_valid<=0 at the next edge; out_data/out_sel keep their previous value; ptr unchanged.
- Stall (out_valid & ~out_ready): out_data, out_sel, out_valid and ptr are all held; in_ready=0.
- Simultaneous out_ready and new transfer: the old beat is consumed and the new beat is loaded at the same edge, with no bubble. Sustained throughput is 1 beat/cycle.
- Latency: 1 cycle from the in_valid&in_ready edge to out_valid.
- Fairness (RR_MODE=1): with all N channels continuously valid and out_ready=1, each channel is granted exactly once every N cycles.
- in_valid dropping without a handshake is legal. The arbiter simply re-evaluates each cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0; first grant after release goes to ch0.
- Round-robin rotation: N=4, WIDTH=8, in_data={8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 and out_data 11,22,33,44,11,22, starting 1 cycle after release.
- Back-pressure: out_ready=0 for 3 cycles while beat out_sel=1 (data 22) is held -> out_data stays 22, in_ready=0. Raise out_ready -> next beat is ch2 (33) on the following edge, with no bubble.
- Sparse/wrap: N=3, ptr=2, only ch0 valid -> ch0 granted, ptr becomes 1. Then only ch2 valid -> ch2 granted, ptr wraps to 0.
- Fixed priority: RR_MODE=0, ch1 and ch3 continuously valid, out_ready=1 -> out_sel=1 every cycle; ch3 is never granted until ch1 deasserts.
- Reset mid-stall: out_valid=1 holding 33, assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0, ptr=0 at that edge; held beat is lost.

Source files
------------

// File: rtl/mux_rr_n.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_n
//  Purpose  : N-channel, WIDTH-bit registered multiplexer with per-channel
//             valid/ready handshake and an internal arbiter (round-robin or
//             fixed lowest-index priority). One output register stage,
//             1-cycle latency, full throughput.
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_n #(
  parameter int WIDTH   = 64,
  parameter int N       = 4,
  parameter int RR_MODE = 1,
  parameter int SELW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Registered state and its next-state values
  logic [SELW-1:0]  ptr_q,       ptr_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_sel_q,   out_sel_d;
  logic             out_valid_q, out_valid_d;

  // Arbiter results
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             reg_free;
  logic             xfer;

  // The output register can take a new beat when empty or being drained now
  assign reg_free = ~out_valid_q | out_ready;

  // Arbiter: scan from ptr (RR) or from 0 (fixed) and take the first valid channel.
  // The candidate index is one bit wider than SELW so ptr+k never overflows
  // before the modulo-N fold, which keeps non-power-of-2 N correct.
  always_comb begin : p_grant
    logic [SELW:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      if (RR_MODE != 0) begin
        cand = {1'b0, ptr_q} + (SELW+1)'(k);
      end else begin
        cand = (SELW+1)'(k);
      end
      if (cand >= (SELW+1)'(N)) begin
        cand = cand - (SELW+1)'(N);
      end
      if (!grant_valid && in_valid[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[SELW-1:0];
      end
    end
  end

  // A transfer happens only out of reset, into a free register, on a valid grant
  assign xfer = rst_n & reg_free & grant_valid;

  // One-hot ready for the granted channel, forced low during reset
  always_comb begin : p_ready
    in_ready = '0;
    if (xfer) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state: load on transfer, clear valid when free and idle, hold on stall
  always_comb begin : p_next
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (reg_free) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d  = grant_idx;
      if (RR_MODE != 0) begin
        if (grant_idx == SELW'(N-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = grant_idx + 1'b1;
        end
      end else begin
        ptr_d = '0;
      end
    end
  end

  // State register with synchronous active-low reset; reset drops any held beat
  always_ff @(posedge clk) begin : p_regs
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_rr_n
//  Purpose  : Scoreboard bench for mux_rr_n. Three instances: N=4 round-robin,
//             N=3 round-robin, N=4 fixed priority (all WIDTH=8). Stimulus
//             pushes expected {sel,data} beats; per-instance monitors pop and
//             compare on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_rr_n;

  logic clk;
  int   n_cmp;
  int   n_err;

  // Instance A: N=4, RR
  logic        a_rst_n;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_sel;
  logic        a_out_valid, a_out_ready;
  // Instance B: N=3, RR
  logic        b_rst_n;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_valid, b_out_ready;
  // Instance C: N=4, fixed priority
  logic        c_rst_n;
  logic [31:0] c_in_data;
  logic [3:0]  c_in_valid, c_in_ready;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_sel;
  logic        c_out_valid, c_out_ready;

  logic [9:0] qa[$];
  logic [9:0] qb[$];
  logic [9:0] qc[$];
  logic [9:0] ea, eb, ec;

  mux_rr_n #(.WIDTH(8), .N(4), .RR_MODE(1)) u_a (
    .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  mux_rr_n #(.WIDTH(8), .N(3), .RR_MODE(1)) u_b (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  mux_rr_n #(.WIDTH(8), .N(4), .RR_MODE(0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_sel(c_out_sel),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a beat is consumed when valid & ready are both seen mid-cycle
  always @(negedge clk) begin
    if (a_rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_beat: got %0h expected none", {a_out_sel, a_out_data});
      end else begin
        ea = qa.pop_front();
        chk("a_beat", {a_out_sel, a_out_data}, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_beat: got %0h expected none", {b_out_sel, b_out_data});
      end else begin
        eb = qb.pop_front();
        chk("b_beat", {b_out_sel, b_out_data}, eb);
      end
    end
  end

  always @(negedge clk) begin
    if (c_rst_n && c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL c_unexpected_beat: got %0h expected none", {c_out_sel, c_out_data});
      end else begin
        ec = qc.pop_front();
        chk("c_beat", {c_out_sel, c_out_data}, ec);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    a_in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    b_in_data = {8'hC2, 8'hB1, 8'hA0};
    c_in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_in_valid = 4'hF; b_in_valid = 3'h7; c_in_valid = 4'hF;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;

    // ---------------- Reset with all inputs valid ----------------
    tick();
    tick();
    @(negedge clk);
    chk("rst_a_in_ready", a_in_ready, 4'b0000);
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_data", a_out_data, 8'h00);
    chk("rst_a_out_sel", a_out_sel, 2'd0);
    chk("rst_b_in_ready", b_in_ready, 3'b000);
    chk("rst_c_in_ready", c_in_ready, 4'b0000);
    chk("rst_c_out_valid", c_out_valid, 1'b0);

    // ---------------- A: rotation, back-pressure, reset mid-stall ----------------
    tick();
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    b_in_valid = 3'b000; c_in_valid = 4'b0000;
    @(negedge clk);
    chk("a_first_grant", a_in_ready, 4'b0001);
    chk("a_no_out_yet", a_out_valid, 1'b0);
    qa.push_back({2'd0, 8'h11});
    qa.push_back({2'd1, 8'h22});
    qa.push_back({2'd2, 8'h33});
    qa.push_back({2'd3, 8'h44});
    qa.push_back({2'd0, 8'h11});
    qa.push_back({2'd1, 8'h22});
    tick();
    @(negedge clk);
    chk("a_latency_valid", a_out_valid, 1'b1);
    repeat (5) tick();
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("a_stall_sel", a_out_sel, 2'd1);
    chk("a_stall_in_ready", a_in_ready, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("a_stall_data", a_out_data, 8'h22);
      chk("a_stall_valid", a_out_valid, 1'b1);
      chk("a_stall_in_ready", a_in_ready, 4'b0000);
    end
    tick();
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("a_resume_data", a_out_data, 8'h22);
    chk("a_resume_grant", a_in_ready, 4'b0100);
    tick();
    a_out_ready = 1'b0;
    @(negedge clk);
    chk("a_nobubble_data", a_out_data, 8'h33);
    chk("a_nobubble_sel", a_out_sel, 2'd2);
    chk("a_nobubble_valid", a_out_valid, 1'b1);
    tick();
    a_rst_n = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    chk("a_rst_gate_ready", a_in_ready, 4'b0000);
    tick();
    a_rst_n = 1'b1;
    @(negedge clk);
    chk("a_midrst_valid", a_out_valid, 1'b0);
    chk("a_midrst_data", a_out_data, 8'h00);
    chk("a_midrst_sel", a_out_sel, 2'd0);
    chk("a_midrst_ptr0", a_in_ready, 4'b0001);
    qa.push_back({2'd0, 8'h11});
    tick();
    a_in_valid = 4'b0000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("a_idle_valid", a_out_valid, 1'b0);
    chk("a_idle_keep_data", a_out_data, 8'h11);

    // ---------------- B: N=3 sparse grants and pointer wrap ----------------
    tick();
    b_in_valid = 3'b010;
    @(negedge clk);
    chk("b_grant_ch1", b_in_ready, 3'b010);
    qb.push_back({2'd1, 8'hB1});
    tick();
    b_in_valid = 3'b001;
    @(negedge clk);
    chk("b_ptr2_ch0", b_in_ready, 3'b001);
    qb.push_back({2'd0, 8'hA0});
    tick();
    b_in_valid = 3'b101;
    @(negedge clk);
    chk("b_ptr1_ch2", b_in_ready, 3'b100);
    qb.push_back({2'd2, 8'hC2});
    tick();
    b_in_valid = 3'b111;
    @(negedge clk);
    chk("b_wrap_ptr0", b_in_ready, 3'b001);
    qb.push_back({2'd0, 8'hA0});
    tick();
    b_in_valid = 3'b000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("b_idle_valid", b_out_valid, 1'b0);

    // ---------------- C: fixed priority ----------------
    tick();
    c_in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("c_fixed_ch1", c_in_ready, 4'b0010);
      qc.push_back({2'd1, 8'h22});
      tick();
    end
    c_in_valid = 4'b1000;
    @(negedge clk);
    chk("c_ch3_after_drop", c_in_ready, 4'b1000);
    qc.push_back({2'd3, 8'h44});
    tick();
    c_in_valid = 4'b0000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("c_idle_valid", c_out_valid, 1'b0);

    // Every expected beat must have been delivered
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    chk("c_queue_drained", 64'(qc.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
